// File: rtl/max_pool_unit.sv
// ---------------------------------------------------------------------------
// max_pool_unit
//
// Streaming 2x2 / stride-2 signed max pooling over a raster-ordered feature
// map, all CH_NUM channels in parallel. The block can also run in bypass
// mode, which passes pixels through unpooled with one cycle of latency.
//
// Ports
//   clk                 : rising-edge clock
//   rst                 : asynchronous active-high reset
//   pool_data_in        : one pixel, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   pool_data_valid_in  : pool_data_in carries a pixel this cycle
//   pool_bypass         : 1 = pass through unpooled; taken at frame start only
//   pool_clear          : synchronous return to row 0 / col 0
//   pool_data_out       : pooled (or bypassed) pixel, same channel packing
//   pool_data_valid_out : pool_data_out carries a pixel this cycle
//   frame_done          : one-cycle pulse marking the end of a frame
//
// Handshake: a beat is transferred on every rising edge where
// pool_data_valid_in=1; there is no ready, so the source never stalls and
// the block must accept every beat. On the output side, pool_data_out is
// meaningful only on cycles where pool_data_valid_out=1 and the consumer
// must take it on that cycle. frame_done can assert without
// pool_data_valid_out when the final input row is a discarded odd row.
// ---------------------------------------------------------------------------
module max_pool_unit #(
  parameter int CH_NUM     = 18,
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 318,
  parameter int IMG_HEIGHT = 318
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CH_NUM*DATA_WIDTH-1:0] pool_data_in,
  input  logic                         pool_data_valid_in,
  input  logic                         pool_bypass,
  input  logic                         pool_clear,
  output logic [CH_NUM*DATA_WIDTH-1:0] pool_data_out,
  output logic                         pool_data_valid_out,
  output logic                         frame_done
);

  localparam int PW       = CH_NUM * DATA_WIDTH;
  localparam int CW       = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW       = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int LB_DEPTH = (IMG_WIDTH / 2 > 0) ? IMG_WIDTH / 2 : 1;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_WIDTH - 1);
  // Odd column of the last complete horizontal pair in a row.
  localparam logic [CW-1:0] COL_LAST_PAIR = CW'(2 * (IMG_WIDTH / 2) - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_HEIGHT - 1);
  localparam bit            H_ODD         = (IMG_HEIGHT % 2) != 0;

  // Per-channel signed maximum; ties return the shared value.
  function automatic logic [PW-1:0] chan_max(input logic [PW-1:0] a,
                                             input logic [PW-1:0] b);
    logic [PW-1:0] r;
    r = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      if ($signed(a[c*DATA_WIDTH +: DATA_WIDTH]) >=
          $signed(b[c*DATA_WIDTH +: DATA_WIDTH]))
        r[c*DATA_WIDTH +: DATA_WIDTH] = a[c*DATA_WIDTH +: DATA_WIDTH];
      else
        r[c*DATA_WIDTH +: DATA_WIDTH] = b[c*DATA_WIDTH +: DATA_WIDTH];
    end
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [PW-1:0]    held;       // even-column pixel waiting for its partner
  logic             bypass_q;   // mode captured while sitting at the origin
  logic [PW-1:0]    lb_mem [0:LB_DEPTH-1];

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  logic             at_origin;
  logic             mode_bypass;
  logic             beat;
  logic             col_odd;
  logic             row_odd;
  logic             col_wrap;
  logic             row_wrap;
  logic             pool_fire;
  logic             lb_write;
  logic             done_fire;
  logic [LB_AW-1:0] lb_addr;
  logic [PW-1:0]    lb_rd;
  logic [PW-1:0]    hmax;
  logic [PW-1:0]    vmax;

  always_comb begin
    at_origin = (row == '0) && (col == '0);
    // The first beat of a frame already follows the live pool_bypass value;
    // every later beat uses the copy captured at the origin.
    mode_bypass = at_origin ? pool_bypass : bypass_q;
    // Clear wins over a simultaneous valid: that beat has no effect at all.
    beat      = pool_data_valid_in && !pool_clear;
    col_odd   = col[0];
    row_odd   = row[0];
    col_wrap  = (col == COL_LAST);
    row_wrap  = (row == ROW_LAST);
    lb_addr   = LB_AW'(col >> 1);
    lb_rd     = lb_mem[lb_addr];
    hmax      = chan_max(held, pool_data_in);
    vmax      = chan_max(hmax, lb_rd);
    pool_fire = beat && !mode_bypass && col_odd && row_odd;
    lb_write  = beat && !mode_bypass && col_odd && !row_odd;
    // With an odd height the trailing row is consumed silently, so the
    // frame ends on the very last beat rather than on the last pooled one.
    if (mode_bypass)
      done_fire = beat && row_wrap && col_wrap;
    else if (H_ODD)
      done_fire = beat && row_wrap && col_wrap;
    else
      done_fire = beat && row_wrap && (col == COL_LAST_PAIR);
  end

  // -------------------------------------------------------------------------
  // Frame position
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (pool_clear) begin
      col <= '0;
      row <= '0;
    end else if (pool_data_valid_in) begin
      if (col_wrap) begin
        col <= '0;
        row <= row_wrap ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Bypass capture: resampled every cycle the block is idle at the origin,
  // frozen for the rest of the frame.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bypass_q <= 1'b0;
    else if (at_origin)
      bypass_q <= pool_bypass;
  end

  // -------------------------------------------------------------------------
  // Horizontal pairing register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      held <= '0;
    else if (beat && !col_odd)
      held <= pool_data_in;
  end

  // -------------------------------------------------------------------------
  // Line buffer: even rows deposit the horizontal max, odd rows read it back.
  // No reset: every entry is rewritten on an even row before it is read,
  // which also covers stale data left by a discarded odd last row.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (lb_write)
      lb_mem[lb_addr] <= hmax;
  end

  // -------------------------------------------------------------------------
  // Output register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pool_data_out       <= '0;
      pool_data_valid_out <= 1'b0;
      frame_done          <= 1'b0;
    end else begin
      pool_data_valid_out <= pool_fire || (beat && mode_bypass);
      frame_done          <= done_fire;
      if (pool_fire)
        pool_data_out <= vmax;
      else if (beat && mode_bypass)
        pool_data_out <= pool_data_in;
    end
  end

endmodule

// File: tb/tb_max_pool_unit.sv
// ---------------------------------------------------------------------------
// tb_max_pool_unit
//
// Two instances: a 4x4 unit (a_*) for pooling, signed compare, gaps, clear,
// bypass and reset, and a 5x5 unit (b_*) for odd-size frames. Two channels
// per pixel: channel 0 carries the raster value, channel 1 its negation.
// Expected entries are {cycle[15:0], valid, done, ch1, ch0}.
// ---------------------------------------------------------------------------
module tb_max_pool_unit;

  localparam int DW = 8;
  localparam int CH = 2;
  localparam int PW = CH * DW;
  localparam int EW = 16 + 2 + PW;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // -------------------------------------------------------------------------
  // DUTs
  // -------------------------------------------------------------------------
  logic [PW-1:0] a_din, a_dout, b_din, b_dout;
  logic          a_vin, a_byp, a_clr, a_vout, a_done;
  logic          b_vin, b_byp, b_clr, b_vout, b_done;

  max_pool_unit #(.CH_NUM(CH), .DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
    .clk(clk), .rst(rst),
    .pool_data_in(a_din), .pool_data_valid_in(a_vin),
    .pool_bypass(a_byp), .pool_clear(a_clr),
    .pool_data_out(a_dout), .pool_data_valid_out(a_vout), .frame_done(a_done)
  );

  max_pool_unit #(.CH_NUM(CH), .DATA_WIDTH(DW), .IMG_WIDTH(5), .IMG_HEIGHT(5)) dut_b (
    .clk(clk), .rst(rst),
    .pool_data_in(b_din), .pool_data_valid_in(b_vin),
    .pool_bypass(b_byp), .pool_clear(b_clr),
    .pool_data_out(b_dout), .pool_data_valid_out(b_vout), .frame_done(b_done)
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  logic [EW-1:0] exp_a[$];
  logic [EW-1:0] exp_b[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin : mon_a
    logic [EW-1:0] e;
    if (!rst) begin
      while (exp_a.size() > 0 && int'(exp_a[0][EW-1:EW-16]) < cyc) begin
        e = exp_a.pop_front();
        checks++;
        failures++;
        $display("FAIL a_missing_output actual=none required_cycle=%0d data=%0h", e[EW-1:EW-16], e[PW-1:0]);
      end
      if (a_vout || a_done) begin
        if (exp_a.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL a_unexpected_output actual=valid:%0b done:%0b data:%0h required=none (cycle %0d)",
                   a_vout, a_done, a_dout, cyc);
        end else begin
          e = exp_a.pop_front();
          chk("a_latency_cycle", 32'(cyc[15:0]), 32'(e[EW-1:EW-16]));
          chk("a_valid", 32'(a_vout), 32'(e[PW+1]));
          chk("a_frame_done", 32'(a_done), 32'(e[PW]));
          if (e[PW+1]) chk("a_data", 32'(a_dout), 32'(e[PW-1:0]));
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [EW-1:0] e;
    if (!rst) begin
      while (exp_b.size() > 0 && int'(exp_b[0][EW-1:EW-16]) < cyc) begin
        e = exp_b.pop_front();
        checks++;
        failures++;
        $display("FAIL b_missing_output actual=none required_cycle=%0d data=%0h", e[EW-1:EW-16], e[PW-1:0]);
      end
      if (b_vout || b_done) begin
        if (exp_b.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b_unexpected_output actual=valid:%0b done:%0b data:%0h required=none (cycle %0d)",
                   b_vout, b_done, b_dout, cyc);
        end else begin
          e = exp_b.pop_front();
          chk("b_latency_cycle", 32'(cyc[15:0]), 32'(e[EW-1:EW-16]));
          chk("b_valid", 32'(b_vout), 32'(e[PW+1]));
          chk("b_frame_done", 32'(b_done), 32'(e[PW]));
          if (e[PW+1]) chk("b_data", 32'(b_dout), 32'(e[PW-1:0]));
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus tables
  // -------------------------------------------------------------------------
  logic [7:0] in0 [16];
  logic [7:0] in1 [16];
  logic [7:0] ex0 [4];
  logic [7:0] ex1 [4];
  logic [7:0] e5_0 [4];
  logic [7:0] e5_1 [4];

  task automatic load_std();
    for (int i = 0; i < 16; i++) begin
      in0[i] = 8'(i);
      in1[i] = 8'(-i);
    end
    ex0 = '{8'd5, 8'd7, 8'd13, 8'd15};
    ex1 = '{8'h00, 8'hFE, 8'hF8, 8'hF6};
  endtask

  task automatic load_signed();
    in0 = '{8'h80, 8'h7F, 8'hFB, 8'hFD,
            8'hFF, 8'h00, 8'h80, 8'hFC,
            8'h80, 8'h80, 8'hFE, 8'hF9,
            8'h80, 8'h80, 8'hF7, 8'hFE};
    for (int i = 0; i < 16; i++) in1[i] = 8'h00;
    ex0 = '{8'h7F, 8'hFD, 8'h80, 8'hFE};
    ex1 = '{8'h00, 8'h00, 8'h00, 8'h00};
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks (called at posedge + #1)
  // -------------------------------------------------------------------------
  task automatic push(input bit sel, input logic [7:0] e0, input logic [7:0] e1,
                      input logic vld, input logic done);
    logic [EW-1:0] e;
    e = {16'(cyc + 1), vld, done, e1, e0};
    if (!sel) exp_a.push_back(e);
    else      exp_b.push_back(e);
  endtask

  task automatic beat(input bit sel, input logic [7:0] c0, input logic [7:0] c1);
    if (!sel) begin a_vin = 1'b1; a_din = {c1, c0}; end
    else      begin b_vin = 1'b1; b_din = {c1, c0}; end
    @(posedge clk); #1;
    a_vin = 1'b0;
    b_vin = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // 4x4 frame on dut_a. byp selects which result the bench expects;
  // tog_at flips pool_bypass alongside that beat; clr_at asserts pool_clear
  // with that beat.
  task automatic frame4(input bit byp, input bit gaps, input int nbeats,
                        input int tog_at, input int clr_at);
    int k;
    k = 0;
    for (int i = 0; i < nbeats; i++) begin
      if (gaps) idle($urandom_range(0, 2));
      if (i == tog_at) a_byp = ~a_byp;
      if (i == clr_at) a_clr = 1'b1;
      else if (byp) push(1'b0, in0[i], in1[i], 1'b1, i == 15);
      else if (i == 5 || i == 7 || i == 13 || i == 15) begin
        push(1'b0, ex0[k], ex1[k], 1'b1, i == 15);
        k++;
      end
      beat(1'b0, in0[i], in1[i]);
      a_clr = 1'b0;
    end
  endtask

  // 5x5 frame on dut_b, values 0..24; column 4 and row 4 are discarded.
  task automatic frame5();
    int k;
    k = 0;
    for (int i = 0; i < 25; i++) begin
      if (i == 6 || i == 8 || i == 16 || i == 18) begin
        push(1'b1, e5_0[k], e5_1[k], 1'b1, 1'b0);
        k++;
      end
      if (i == 24) push(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
      beat(1'b1, 8'(i), 8'(-i));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_a_data"},  32'(a_dout), 32'h0);
    chk({tag, "_a_valid"}, 32'(a_vout), 32'h0);
    chk({tag, "_a_done"},  32'(a_done), 32'h0);
    chk({tag, "_b_data"},  32'(b_dout), 32'h0);
    chk({tag, "_b_valid"}, 32'(b_vout), 32'h0);
    chk({tag, "_b_done"},  32'(b_done), 32'h0);
  endtask

  // -------------------------------------------------------------------------
  // Test sequence
  // -------------------------------------------------------------------------
  initial begin
    rst   = 1'b1;
    a_din = '0; a_vin = 1'b0; a_byp = 1'b0; a_clr = 1'b0;
    b_din = '0; b_vin = 1'b0; b_byp = 1'b0; b_clr = 1'b0;
    e5_0 = '{8'd6, 8'd8, 8'd16, 8'd18};
    e5_1 = '{8'h00, 8'hFE, 8'hF6, 8'hF4};
    idle(3);
    chk_reset_outputs("reset");
    rst = 1'b0;
    idle(2);

    // Plain 4x4 pooling
    load_std();
    frame4(1'b0, 1'b0, 16, -1, -1);
    idle(2);

    // Signed compare windows
    load_signed();
    frame4(1'b0, 1'b0, 16, -1, -1);
    idle(2);

    // Random gaps in valid
    load_std();
    frame4(1'b0, 1'b1, 16, -1, -1);
    idle(2);

    // Partial frame ended by clear on the 6th beat, then a fresh frame
    frame4(1'b0, 1'b0, 6, -1, 5);
    idle(2);
    frame4(1'b0, 1'b0, 16, -1, -1);
    idle(2);

    // Bypass raised mid pooled frame: pooled until the frame ends
    frame4(1'b0, 1'b0, 16, 8, -1);
    idle(2);
    // Bypass now set at idle: pass-through frame; dropping it mid-frame
    // keeps bypass until the frame ends
    frame4(1'b1, 1'b0, 16, 8, -1);
    idle(2);
    frame4(1'b0, 1'b0, 16, -1, -1);
    idle(2);

    // Reset after 9 beats, then a full frame
    frame4(1'b0, 1'b0, 9, -1, -1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    idle(2);
    chk_reset_outputs("midreset_hold");
    rst = 1'b0;
    idle(1);
    frame4(1'b0, 1'b0, 16, -1, -1);
    idle(2);

    // Odd size 5x5, twice back to back
    frame5();
    idle(2);
    frame5();
    idle(4);

    chk("a_queue_drained", 32'(exp_a.size()), 32'h0);
    chk("b_queue_drained", 32'(exp_b.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
